// File: rtl/instr_sequencer_if.sv
// Instruction-ROM and ALU side bus of the instruction sequencer.
// master = sequencer, slave = ROM/ALU environment.
interface instr_sequencer_if;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [4:0]  alu_op;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    logic [2:0]  alu_im;
    logic [7:0]  alu_im8;
    logic [7:0]  alu_res;
    logic        alu_jmp;

    modport master (
        output imem_addr, alu_op, alu_in1, alu_in2, alu_im, alu_im8,
        input  imem_data, alu_res, alu_jmp
    );

    modport slave (
        input  imem_addr, alu_op, alu_in1, alu_in2, alu_im, alu_im8,
        output imem_data, alu_res, alu_jmp
    );
endinterface

// File: rtl/instr_sequencer.sv
// Four-phase fetch/decode/execute/writeback sequencer driving the 8-bit ALU.
// Owns the PC and an 8x8 register file; ALU flags stay inside the ALU.
module instr_sequencer #(
    parameter int PC_W     = 8,
    parameter int RF_DEPTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run,
    instr_sequencer_if.master   bus,
    output logic [7:0]          show_data,
    output logic                show_valid,
    output logic                instr_done,
    output logic [PC_W-1:0]     pc
);
    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [15:0]     ir_q, ir_d;
    logic [7:0]      rf_q [RF_DEPTH];
    logic [7:0]      rf_d [RF_DEPTH];
    logic [7:0]      in1_q, in1_d;
    logic [7:0]      in2_q, in2_d;
    logic [7:0]      show_q, show_d;
    logic            done;
    logic            shv;
    logic            alu_act;
    logic [4:0]      op;
    logic [2:0]      rd;

    assign op = ir_q[15:11];
    assign rd = ir_q[10:8];

    function automatic logic writes_rd(input logic [4:0] o);
        return o inside {[5'd1:5'd6], [5'd8:5'd16], 5'd20, 5'd21, 5'd30};
    endfunction

    function automatic logic is_show(input logic [4:0] o);
        return o inside {5'd19, 5'd31};
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        rf_d    = rf_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        show_d  = show_q;
        done    = 1'b0;
        shv     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                addr_d = pc_q;
                if (run) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Operands are captured here so the ALU sees them in EXECUTE.
                ir_d    = bus.imem_data;
                in1_d   = rf_q[bus.imem_data[10:8]];
                in2_d   = rf_q[bus.imem_data[7:5]];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                done = 1'b1;
                if (writes_rd(op)) begin
                    rf_d[rd] = bus.alu_res;
                end
                if (is_show(op)) begin
                    shv    = 1'b1;
                    show_d = bus.alu_res;
                end
                pc_d    = bus.alu_jmp ? PC_W'(bus.alu_res) : pc_q + 1'b1;
                addr_d  = pc_d;
                in1_d   = '0;
                in2_d   = '0;
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            show_q  <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            show_q  <= show_d;
            rf_q    <= rf_d;
        end
    end

    assign alu_act = (state_q == S_EXEC) || (state_q == S_WB);

    assign bus.imem_addr = addr_q;
    assign bus.alu_op    = alu_act ? op : '0;
    assign bus.alu_im    = alu_act ? ir_q[2:0] : '0;
    assign bus.alu_im8   = alu_act ? ir_q[7:0] : '0;
    assign bus.alu_in1   = in1_q;
    assign bus.alu_in2   = in2_q;

    // A reset arriving in WRITEBACK suppresses the pulses of the aborted op.
    assign instr_done = done & ~reset;
    assign show_valid = shv & ~reset;
    assign show_data  = show_valid ? bus.alu_res : show_q;
    assign pc         = pc_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program then random ROM/run/reset,
// all checked against an instruction-level model every cycle.
module tb_instr_sequencer;
    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] show_data;
    logic       show_valid;
    logic       instr_done;
    logic [7:0] pc;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .bus        (bus.master),
        .show_data  (show_data),
        .show_valid (show_valid),
        .instr_done (instr_done),
        .pc         (pc)
    );

    always #5 clock = ~clock;

    logic [15:0] rom [256];
    logic        force_en;
    logic        force_jmp;

    function automatic logic is_jump(input logic [4:0] o);
        return (o >= 5'd24) && (o <= 5'd29);
    endfunction

    function automatic logic [7:0] alu_fn(input logic [4:0] o,
                                          input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [2:0] im,
                                          input logic [7:0] i8);
        if (o == 5'd30) return i8;
        if (o == 5'd1) return a + b;
        if (o == 5'd22) return a - b;
        if (is_jump(o)) return i8;
        if (o == 5'd31 || o == 5'd19) return a;
        return (a ^ b) + {5'd0, im} + {3'd0, o};
    endfunction

    always @(posedge clock) bus.imem_data <= rom[bus.imem_addr];

    always_comb begin
        bus.alu_res = alu_fn(bus.alu_op, bus.alu_in1, bus.alu_in2,
                             bus.alu_im, bus.alu_im8);
        bus.alu_jmp = force_en ? force_jmp
                               : (is_jump(bus.alu_op) && bus.alu_im8[0]);
    end

    logic [7:0]  m_pc;
    logic [7:0]  m_show;
    logic [7:0]  m_R [8];
    logic [15:0] m_ir;
    int          m_phase;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic m_writes(input logic [4:0] o);
        return (o >= 5'd1 && o <= 5'd6) || (o >= 5'd8 && o <= 5'd16) ||
               o == 5'd20 || o == 5'd21 || o == 5'd30;
    endfunction

    function automatic logic m_show_op(input logic [4:0] o);
        return o == 5'd31 || o == 5'd19;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp,
                     $time);
        end
    endtask

    function automatic logic [7:0] m_res();
        return alu_fn(m_ir[15:11], m_R[m_ir[10:8]], m_R[m_ir[7:5]],
                      m_ir[2:0], m_ir[7:0]);
    endfunction

    task automatic model_step();
        logic [7:0] res;
        logic       jmp;
        logic [4:0] o;
        if (reset) begin
            m_pc    = 8'h00;
            m_show  = 8'h00;
            m_phase = 0;
            for (int i = 0; i < 8; i++) m_R[i] = 8'h00;
        end else if (m_phase == 0) begin
            if (run) m_phase = 1;
        end else if (m_phase == 1) begin
            m_ir    = rom[m_pc];
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 3;
        end else begin
            o   = m_ir[15:11];
            res = m_res();
            jmp = force_en ? force_jmp : (is_jump(o) && m_ir[0]);
            if (m_writes(o)) m_R[m_ir[10:8]] = res;
            if (m_show_op(o)) m_show = res;
            m_pc    = jmp ? res : m_pc + 8'd1;
            m_phase = 0;
        end
    endtask

    task automatic check_cycle();
        logic [4:0] o;
        logic       wb;
        o  = m_ir[15:11];
        wb = (m_phase == 3);
        chk("pc", pc, m_pc);
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("instr_done", instr_done, wb);
        chk("show_valid", show_valid, wb && m_show_op(o));
        chk("show_data", show_data, (wb && m_show_op(o)) ? m_res() : m_show);
        if (m_phase < 2) begin
            chk("alu_op_idle", bus.alu_op, 0);
        end else begin
            chk("alu_op", bus.alu_op, o);
            chk("alu_in1", bus.alu_in1, m_R[m_ir[10:8]]);
            chk("alu_in2", bus.alu_in2, m_R[m_ir[7:5]]);
            chk("alu_im", bus.alu_im, m_ir[2:0]);
            chk("alu_im8", bus.alu_im8, m_ir[7:0]);
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clock);
        check_cycle();
    endtask

    initial begin
        int      cyc;
        int      dones;
        bit [31:0] mask;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0]     = 16'hF105;
        rom[1]     = 16'hF203;
        rom[2]     = 16'h0940;
        rom[3]     = 16'hB140;
        rom[4]     = 16'hF900;
        rom[5]     = 16'hC040;
        rom[8'h40] = 16'hC041;
        rom[8'h41] = 16'hC0FF;
        rom[8'hFF] = 16'h0000;
        m_ir      = 16'h0000;
        force_en  = 1'b0;
        force_jmp = 1'b0;
        reset     = 1'b1;
        run       = 1'b0;

        tick();
        chk("reset_pc", pc, 0);
        chk("reset_show_data", show_data, 0);
        reset = 1'b0;
        run   = 1'b1;
        cyc   = 1;
        mask  = '0;
        for (int i = 0; i < 11; i++) begin
            tick();
            cyc++;
            if (instr_done) mask[cyc] = 1'b1;
        end
        chk("done_cycles", mask, 32'h0000_1110);
        tick();
        chk("pc_after_add", pc, 3);
        chk("model_r1_add", m_R[1], 8'h08);

        repeat (3) tick();
        chk("cmp_done", instr_done, 1);
        tick();
        chk("pc_after_cmp", pc, 4);
        chk("model_r1_cmp", m_R[1], 8'h08);

        repeat (3) tick();
        chk("show_pulse", show_valid, 1);
        chk("show_val", show_data, 8'h08);
        tick();
        chk("show_pulse_end", show_valid, 0);
        chk("show_hold", show_data, 8'h08);

        force_en  = 1'b1;
        force_jmp = 1'b1;
        repeat (4) tick();
        chk("jmp_taken", pc, 8'h40);
        force_jmp = 1'b0;
        repeat (4) tick();
        chk("jmp_not_taken", pc, 8'h41);
        force_jmp = 1'b1;
        repeat (4) tick();
        chk("jmp_to_ff", pc, 8'hFF);
        force_en = 1'b0;
        repeat (4) tick();
        chk("pc_wrap", pc, 0);
        chk("addr_wrap", bus.imem_addr, 0);

        run   = 1'b0;
        dones = 0;
        repeat (10) begin
            tick();
            if (instr_done) dones++;
        end
        chk("park_pc", pc, 0);
        chk("park_dones", dones, 0);

        rom[0] = 16'h0B20;
        rom[1] = 16'hFB00;
        run    = 1'b1;
        repeat (2) tick();
        chk("exec_op_add", bus.alu_op, 5'd1);
        reset = 1'b1;
        tick();
        chk("abort_alu_op", bus.alu_op, 0);
        chk("abort_pc", pc, 0);
        reset = 1'b0;
        repeat (8) tick();
        chk("model_r3_abort", m_R[3], 8'h00);

        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            run   = ($urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Control-side counterpart of the 8-bit ALU. Fetches 16-bit instructions, decodes them and drives the ALU operand, opcode and immediate inputs.
- Consumes the ALU's result and jump request, writes results back into an internal 8x8 register file, and updates the program counter.
- Sits between the instruction ROM and the ALU. The board display path takes its SHOW output.

Parameters:
- PC_W, 8, program counter / instruction address width.
- RF_DEPTH, 8, number of 8-bit general registers (index width 3).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = sequence instructions; 0 = hold in FETCH.
- imem_addr  out  8  instruction address (registered).
- imem_data  in  16  instruction word, valid one cycle after imem_addr.
- alu_op  out  5  opcode to ALU.
- alu_in1  out  8  R[rd].
- alu_in2  out  8  R[rs].
- alu_im  out  3  shift/rotate amount.
- alu_im8  out  8  8-bit immediate / jump target.
- alu_res  in  8  ALU result.
- alu_jmp  in  1  ALU jump-taken flag.
- show_data  out  8  last SHOW value.
- show_valid  out  1  one-cycle pulse when show_data updates.
- instr_done  out  1  one-cycle pulse at WRITEBACK.
- pc  out  8  current program counter.

Behaviour:
- Decode fields: op=ir[15:11], rd=ir[10:8], rs=ir[7:5], im=ir[2:0], im8=ir[7:0].
- FSM states and transitions:
  - FETCH: imem_addr<=pc. Go to DECODE if run=1, else stay.
  - DECODE: ir<=imem_data. Go to EXECUTE.
  - EXECUTE: register alu_op/in1/in2/im/im8 from ir and register file. Go to WRITEBACK.
  - WRITEBACK: sample alu_res/alu_jmp, perform write-back and PC update, pulse instr_done. Go to FETCH.
- Latency: 4 cycles per instruction, with run held high.
- ALU outputs are held stable from EXECUTE through WRITEBACK.
- alu_op reads 00000 (NOP) in FETCH and DECODE.
- Write-back to R[rd]<=alu_res for op in:
  - 00001..00110
  - 01000..10000
  - 10100, 10101
  - 11110
- No register write for:
  - 00000 (NOP), 10110 (CMP)
  - 11000..11101 (jumps)
  - 11111, 10011 (SHOW)
  - all undefined op
- SHOW (11111, 10011): show_data<=alu_res; show_valid=1 for the WRITEBACK cycle only.
- PC update: pc<=alu_res if alu_jmp=1 in WRITEBACK, else pc+1 modulo 256 (255 -> 0).
- Operand sampling for rd==rs: both operands read the same pre-write value. Write occurs only in WRITEBACK, so the next instruction sees the updated value.
- Reset:
  - pc=0, all R=0, ir=0, state=FETCH.
  - alu_op=00000, alu_in1/in2/im/im8=0, imem_addr=0.
  - show_data=0, show_valid=0, instr_done=0.
  - Reset in any state aborts the instruction: no register write, no PC change, no pulses.
- run deasserted mid-instruction: the current instruction completes and the FSM then parks in FETCH. Dropping run in WRITEBACK still lets the PC update.
- Flags are owned by the ALU; this block never stores them.

Test Plan:
- reset; ROM[0]=LI R1,0x05 (11110_001_00000101), ROM[1]=LI R2,0x03, ROM[2]=ADD R1,R2 (ALU model adds) -> R1=0x08 after 12 cycles; pc=3; instr_done pulses at cycles 4,8,12.
- ROM[3]=CMP R1,R2 with ALU res=0x05 -> R1 stays 0x08; instr_done pulses; pc=4.
- JMP 0x40 with ALU model alu_jmp=1, res=0x40 -> pc=0x40 at FETCH after WRITEBACK. Same with alu_jmp=0 -> pc=prev+1.
- pc=0xFF executing NOP -> pc wraps to 0x00; imem_addr=0x00 next FETCH.
- SHOW R1 with res=0x08 -> show_data=0x08, show_valid high exactly 1 cycle; no register change.
- reset asserted during EXECUTE of ADD R3 -> R3=0, pc=0, alu_op=00000 next cycle.
- run=0 held for 10 cycles -> FSM stays in FETCH, pc unchanged, no instr_done.
